wm_input_conditioner: RTL and testbench

Front-end stage feeding the washing machine controller top level. Takes the raw asynchronous panel inputs (start/pause button, door sensor, 2-bit mode switch), synchronises and debounces each one, and drives clean levels and single-cycle event pulses into the controller. It also freezes the mode selection while a wash cycle is running.

---
 rtl/wm_input_conditioner.sv | 113 +++++++++++
 tb/tb_wm_input_conditioner.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wm_input_conditioner.sv
// Panel input front end for the washing machine controller: two-flop synchronisers,
// per-channel debouncers, registered event pulses, and a run-time lock on the mode selection.
module wm_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_pause_raw,
    input  logic       door_raw,
    input  logic [1:0] mode_raw,
    input  logic       lock_mode,
    output logic       start_pause_pulse,
    output logic       door_closed,
    output logic       door_open_pulse,
    output logic [1:0] mode_sel,
    output logic       mode_changed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Synchroniser bus layout: {start_pause, door, mode[1:0]}
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic       sp_sync;
    logic       door_sync;
    logic [1:0] mode_sync;
    logic [1:0] mode_prev;

    logic             sp_stable;
    logic [CNT_W-1:0] sp_cnt, sp_cnt_nxt;
    logic [CNT_W-1:0] door_cnt, door_cnt_nxt;
    logic [CNT_W-1:0] mode_cnt, mode_cnt_nxt;

    logic sp_accept;
    logic door_accept;
    logic mode_accept;
    logic mode_moved;

    assign sp_sync   = sync2[3];
    assign door_sync = sync2[2];
    assign mode_sync = sync2[1:0];

    // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
    always_comb begin
        sp_accept    = (sp_cnt == CNT_MAX) && (sp_sync != sp_stable);
        door_accept  = (door_cnt == CNT_MAX) && (door_sync != door_closed);
        mode_moved   = (mode_sync != mode_prev);
        // A mode value that only just arrived has not been held long enough, and the lock
        // defers acceptance until the first unlocked edge.
        mode_accept  = (mode_cnt == CNT_MAX) && (mode_sync != mode_sel) && !mode_moved && !lock_mode;

        sp_cnt_nxt   = sp_cnt;
        door_cnt_nxt = door_cnt;
        mode_cnt_nxt = mode_cnt;

        if (sp_sync == sp_stable || sp_accept)
            sp_cnt_nxt = '0;
        else if (sp_cnt != CNT_MAX)
            sp_cnt_nxt = sp_cnt + CNT_ONE;

        if (door_sync == door_closed || door_accept)
            door_cnt_nxt = '0;
        else if (door_cnt != CNT_MAX)
            door_cnt_nxt = door_cnt + CNT_ONE;

        // On a mid-count change the count restarts, with the new value's first sample as 1
        // so every channel shares the same acceptance latency.
        if (mode_sync == mode_sel || mode_accept)
            mode_cnt_nxt = '0;
        else if (mode_moved)
            mode_cnt_nxt = CNT_ONE;
        else if (mode_cnt != CNT_MAX)
            mode_cnt_nxt = mode_cnt + CNT_ONE;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and clears every register, synchroniser flops included.
        if (reset) begin
            sync1             <= '0;
            sync2             <= '0;
            mode_prev         <= '0;
            sp_stable         <= 1'b0;
            door_closed       <= 1'b0;
            mode_sel          <= 2'b00;
            sp_cnt            <= '0;
            door_cnt          <= '0;
            mode_cnt          <= '0;
            start_pause_pulse <= 1'b0;
            door_open_pulse   <= 1'b0;
            mode_changed      <= 1'b0;
        end else begin
            sync1             <= {start_pause_raw, door_raw, mode_raw};
            sync2             <= sync1;
            mode_prev         <= mode_sync;
            sp_cnt            <= sp_cnt_nxt;
            door_cnt          <= door_cnt_nxt;
            mode_cnt          <= mode_cnt_nxt;
            start_pause_pulse <= sp_accept && sp_sync;
            door_open_pulse   <= door_accept && !door_sync;
            mode_changed      <= mode_accept;
            if (sp_accept)
                sp_stable <= sp_sync;
            if (door_accept)
                door_closed <= door_sync;
            if (mode_accept)
                mode_sel <= mode_sync;
        end
    end

endmodule

// File: tb/tb_wm_input_conditioner.sv
// Scoreboard bench for wm_input_conditioner with DEBOUNCE_CYCLES=8: directed stimulus
// queues the expected pulses, a negedge monitor pops and compares each observed pulse.
module tb_wm_input_conditioner;

    localparam int D = 8;
    localparam int LAT = D + 2;

    typedef enum int { EV_START, EV_DOOR_OPEN, EV_MODE } ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       at;
        int       val;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       start_pause_raw;
    logic       door_raw;
    logic [1:0] mode_raw;
    logic       lock_mode;
    logic       start_pause_pulse;
    logic       door_closed;
    logic       door_open_pulse;
    logic [1:0] mode_sel;
    logic       mode_changed;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  edge_n  = 0;
    ev_t exp_q[$];

    wm_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_pause_raw(start_pause_raw),
        .door_raw(door_raw),
        .mode_raw(mode_raw),
        .lock_mode(lock_mode),
        .start_pause_pulse(start_pause_pulse),
        .door_closed(door_closed),
        .door_open_pulse(door_open_pulse),
        .mode_sel(mode_sel),
        .mode_changed(mode_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    task automatic expect_ev(input ev_kind_e kind, input int at, input int val);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic match(input ev_kind_e kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse: got pulse kind %0d at edge %0d, expected none", kind, edge_n);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_edge", edge_n, e.at);
            if (e.val >= 0)
                check("ev_value", val, e.val);
        end
    endtask

    // Monitor: every pulse the DUT presents must match the head of the scoreboard.
    always @(negedge clk) begin
        if (start_pause_pulse) match(EV_START, -1);
        if (door_open_pulse)   match(EV_DOOR_OPEN, int'(door_closed));
        if (mode_changed)      match(EV_MODE, int'(mode_sel));
    end

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset           = 1'b1;
        start_pause_raw = 1'b0;
        door_raw        = 1'b0;
        mode_raw        = 2'b00;
        lock_mode       = 1'b0;
        wait_edges(3);

        check("rst_start_pulse", int'(start_pause_pulse), 0);
        check("rst_door_closed", int'(door_closed), 0);
        check("rst_door_pulse", int'(door_open_pulse), 0);
        check("rst_mode_sel", int'(mode_sel), 0);
        check("rst_mode_changed", int'(mode_changed), 0);

        // Door closed from reset release: level rises on edge 10, no pulse.
        door_raw = 1'b1;
        wait_edges(1);
        reset = 1'b0;
        wait_edges(LAT - 1);
        check("door_before_latency", int'(door_closed), 0);
        wait_edges(1);
        check("door_at_latency", int'(door_closed), 1);

        // Clean press, then release with no pulse.
        start_pause_raw = 1'b1;
        expect_ev(EV_START, edge_n + LAT, -1);
        wait_edges(20);
        start_pause_raw = 1'b0;
        wait_edges(20);

        // Bouncing button: 3 high / 3 low never qualifies, then settles high.
        for (int i = 0; i < 40; i++) begin
            start_pause_raw = ((i % 6) < 3);
            wait_edges(1);
        end
        start_pause_raw = 1'b1;
        expect_ev(EV_START, edge_n + LAT, -1);
        wait_edges(20);
        start_pause_raw = 1'b0;
        wait_edges(20);

        // Door opens: level falls with one pulse on the same edge.
        door_raw = 1'b0;
        expect_ev(EV_DOOR_OPEN, edge_n + LAT, 0);
        wait_edges(20);
        check("door_opened", int'(door_closed), 0);
        door_raw = 1'b1;
        wait_edges(20);
        check("door_reclosed", int'(door_closed), 1);

        // Five-cycle open glitch is ignored.
        door_raw = 1'b0;
        wait_edges(5);
        door_raw = 1'b1;
        wait_edges(20);
        check("door_glitch", int'(door_closed), 1);

        // Mode changes mid-count: only the final value is taken.
        mode_raw = 2'b01;
        wait_edges(4);
        mode_raw = 2'b10;
        expect_ev(EV_MODE, edge_n + LAT, 2);
        wait_edges(20);
        check("mode_mid_count", int'(mode_sel), 2);

        // Locked: new selection deferred until the first unlocked edge.
        lock_mode = 1'b1;
        mode_raw  = 2'b11;
        wait_edges(30);
        check("mode_locked_hold", int'(mode_sel), 2);
        lock_mode = 1'b0;
        expect_ev(EV_MODE, edge_n + 1, 3);
        wait_edges(5);
        check("mode_unlocked", int'(mode_sel), 3);

        // Locked, switch wanders and returns before unlock: nothing happens.
        lock_mode = 1'b1;
        mode_raw  = 2'b00;
        wait_edges(30);
        mode_raw  = 2'b11;
        wait_edges(10);
        lock_mode = 1'b0;
        wait_edges(20);
        check("mode_return_no_change", int'(mode_sel), 3);

        // Reset mid-debounce: partial count discarded, all channels re-qualify together.
        start_pause_raw = 1'b1;
        wait_edges(5);
        reset = 1'b1;
        wait_edges(1);
        check("rst_mid_door", int'(door_closed), 0);
        check("rst_mid_mode", int'(mode_sel), 0);
        reset = 1'b0;
        expect_ev(EV_START, edge_n + LAT, -1);
        expect_ev(EV_MODE, edge_n + LAT, 3);
        wait_edges(LAT - 1);
        check("door_requalify_early", int'(door_closed), 0);
        wait_edges(1);
        check("door_requalify", int'(door_closed), 1);
        wait_edges(20);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
